mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single-ported unified memory between the pipeline's instruction fetch (IF) requester and its data-memory (MEM-stage load/store) requester. It grants one access at a time through a handshake with the memory, returns read data and completion pulses to the winner, and drives the per-stage stall signals the pipeline uses to hold IF or MEM. MEM has priority over IF. A burst limit guarantees IF forward progress, and a watchdog guarantees the arbiter never hangs on a missing acknowledge.

## Interface
- MAX_DM_BURST, 4: maximum consecutive data grants while if_req is pending before IF is forced through (≥1).
- TIMEOUT, 64: busy cycles without mem_ack before the watchdog aborts the access (≥2).
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  reset; one clock, asynchronous, active-high.
- if_req  in  1  fetch request; held high with if_addr stable until if_ready.
- if_addr  in  32  fetch word address.
- if_rdata  out  32  fetch data; valid only in the if_ready cycle.
- if_ready  out  1  one-cycle completion pulse to IF.
- dm_req  in  1  data request; held with dm_* stable until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_byte  in  1  byte-sized access (SB/LB/LBU).
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; valid only in the dm_ready cycle.
- dm_ready  out  1  one-cycle completion pulse to MEM.
- mem_en  out  1  memory access active; level, held until mem_ack.
- mem_we, mem_byte  out  1 each  access type for the granted requester (0 for IF).
- mem_addr, mem_wdata  out  32 each  latched address/data of the granted requester.
- mem_rdata  in  32  memory read data; valid in the mem_ack cycle.
- mem_ack  in  1  access complete; one-cycle pulse.
- stall_if, stall_mem  out  1 each  hold the respective stage.
- err  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE: arbitrate on the current if_req/dm_req.
  - Only dm_req: grant DM.
  - Only if_req: grant IF.
  - Both: grant DM unless burst_cnt == MAX_DM_BURST, in which case grant IF.
  - Neither: stay in IDLE.
- Grant: next state is BUSY_x. The granted address, we, byte and wdata are latched into registers that drive the mem_* outputs. wait_cnt is cleared.
- BUSY_x: mem_en=1 and the mem_* outputs stay stable.
  - On mem_ack: x_ready=1 and x_rdata=mem_rdata in the same cycle; next state IDLE.
  - Without mem_ack: wait_cnt increments.
- Watchdog: in a BUSY_x cycle with no mem_ack and wait_cnt == TIMEOUT-1:
  - x_ready=1 and x_rdata=0;
  - err is set and stays set until rst;
  - next state IDLE.
- burst_cnt (width clog2(MAX_DM_BURST+1)):
  - A DM grant while if_req is high increments it, saturating at MAX_DM_BURST.
  - It clears on any IF grant and on any IDLE cycle with if_req low.
- Stall logic (combinational): stall_if = if_req & ~if_ready; stall_mem = dm_req & ~dm_ready.
- if_rdata/dm_rdata are 0 outside their ready cycle. mem_we/mem_byte/mem_wdata are 0 in BUSY_IF.
- A store still waits for mem_ack. dm_rdata for a store is don't-care (it carries mem_rdata).
- A request deasserted mid-access is not cancelled. The access completes and the ready pulse is still produced.

## Timing
- Reset state: IDLE. All outputs 0, including err, mem_en and the stalls (stalls are 0 given req low). burst_cnt=0, wait_cnt=0.
- Reset asserted mid-access: the FSM goes to IDLE immediately, mem_en drops asynchronously, and no ready pulse is produced. The requester re-issues the access.
- Request seen in IDLE at cycle N: mem_en=1 from N+1. The earliest mem_ack is at N+1, which gives ready at N+1 (2-cycle minimum latency).
- After ready, the arbiter always spends one IDLE cycle. Back-to-back throughput is one access per 2 cycles at zero memory wait.
- A requester drops its req or presents the next access the cycle after ready. A req still high in the IDLE cycle is treated as a new request.
- Simultaneous mem_ack and watchdog expiry: mem_ack wins and err is not set.
- mem_ack while in IDLE is ignored and has no effect.

## Test plan
- Reset, then if_req=1, if_addr=0x400, mem_ack returned in the first busy cycle with mem_rdata=0x2402000A:
  - mem_en high at cycle 1;
  - if_ready and if_rdata=0x2402000A at cycle 1;
  - stall_if=1 at cycle 0, stall_if=0 at cycle 1.
- if_req and dm_req (LW, addr 0x1000) rise together: DM is granted first; IF is granted in the IDLE cycle after dm_ready; stall_if stays high throughout the DM access.
- With MAX_DM_BURST=4, if_req held high and dm_req re-issued after every ready: exactly 4 DM accesses, then 1 IF access, then DM resumes.
- SB with dm_addr=0x1003, dm_wdata=0xAB, mem_ack after 3 wait cycles: mem_we=1, mem_byte=1, mem_addr=0x1003 held for 4 cycles; dm_ready on the ack cycle.
- mem_ack withheld with TIMEOUT=64: dm_ready with dm_rdata=0 at the 64th busy cycle; err=1 from the next cycle and still 1 after 10 further accesses.
- rst pulsed during BUSY_DM: mem_en=0 immediately, no dm_ready; the re-issued request is served normally with err=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline requester and unified-memory bus signals of the arbiter
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic        dm_byte;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic        mem_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_byte, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_byte, mem_addr, mem_wdata,
               stall_if, stall_mem, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and MEM with burst limit and watchdog
module mem_port_arbiter #(
    parameter int MAX_DM_BURST = 4,
    parameter int TIMEOUT      = 64
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_DM_BURST + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DM_BURST);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t        state;
    logic [BW-1:0] burst_cnt;
    logic [WW-1:0] wait_cnt;
    logic          en_q;
    logic          we_q;
    logic          byte_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic          grant_dm;
    logic          grant_if;
    logic          busy;
    logic          expire;
    logic          done;

    // arbitration and completion decode; IF is forced through once the data burst is exhausted
    always_comb begin
        grant_dm = bus.dm_req & (~bus.if_req | (burst_cnt != BURST_MAX));
        grant_if = bus.if_req & ~grant_dm;
        busy     = state != IDLE;
        expire   = busy & ~bus.mem_ack & (wait_cnt == WAIT_MAX);
        done     = busy & (bus.mem_ack | expire);
    end

    assign bus.if_ready  = done & (state == BUSY_IF);
    assign bus.dm_ready  = done & (state == BUSY_DM);
    assign bus.if_rdata  = (bus.if_ready & bus.mem_ack) ? bus.mem_rdata : '0;
    assign bus.dm_rdata  = (bus.dm_ready & bus.mem_ack) ? bus.mem_rdata : '0;
    assign bus.stall_if  = bus.if_req & ~bus.if_ready;
    assign bus.stall_mem = bus.dm_req & ~bus.dm_ready;
    assign bus.mem_en    = en_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_byte  = byte_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.err       = err_q;

    // grant latches the winner's access; busy holds it until ack or watchdog expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            wait_cnt  <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else if (state == IDLE) begin
            state     <= grant_dm ? BUSY_DM : grant_if ? BUSY_IF : IDLE;
            en_q      <= grant_dm | grant_if;
            we_q      <= grant_dm & bus.dm_we;
            byte_q    <= grant_dm & bus.dm_byte;
            addr_q    <= grant_dm ? bus.dm_addr : grant_if ? bus.if_addr : '0;
            wdata_q   <= grant_dm ? bus.dm_wdata : '0;
            wait_cnt  <= '0;
            burst_cnt <= (grant_if | ~bus.if_req) ? '0 :
                         (grant_dm && burst_cnt != BURST_MAX) ? burst_cnt + 1'b1 : burst_cnt;
        end else if (done) begin
            state     <= IDLE;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= err_q | expire;
        end else begin
            wait_cnt  <= wait_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus checked against a cycle-level behavioural model
module tb_mem_port_arbiter;
    localparam int MAXB = 4;
    localparam int TMO  = 64;

    typedef struct packed {
        logic        we;
        logic        byt;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();
    mem_port_arbiter #(.MAX_DM_BURST(MAXB), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_chk = 0;
    int          n_fail = 0;
    int          ack_lat = 0;
    bit          stray_ack = 0;
    int          busy_cnt = 0;
    logic [31:0] if_q[$];
    dm_t         dm_q[$];
    string       seq = "";
    bit          if_fired, dm_fired;
    int          m_owner = 0, m_busy = 0, m_streak = 0;
    bit          m_err = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic        m_we = 0, m_byt = 0;
    bit          m_ack, m_tmo, m_done, e_ifr, e_dmr;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chks(string name, string act, string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] rdata_of(logic [31:0] a);
        return (a == 32'h400) ? 32'h2402000A : (a * 3 + 32'h11);
    endfunction

    // requesters: present the head of each queue, retire it the cycle after its ready pulse
    initial begin
        bus.if_req = 0; bus.if_addr = 0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_byte = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
        forever begin
            @(negedge clk);
            if_fired = bus.if_ready;
            dm_fired = bus.dm_ready;
            @(posedge clk); #1;
            if (if_fired) void'(if_q.pop_front());
            if (dm_fired) void'(dm_q.pop_front());
            bus.if_req = if_q.size() != 0;
            if (if_q.size() != 0) bus.if_addr = if_q[0];
            bus.dm_req = dm_q.size() != 0;
            if (dm_q.size() != 0) begin
                bus.dm_we = dm_q[0].we; bus.dm_byte = dm_q[0].byt;
                bus.dm_addr = dm_q[0].addr; bus.dm_wdata = dm_q[0].wdata;
            end
        end
    end

    // memory: acknowledges after ack_lat wait cycles (never when negative)
    initial begin
        bus.mem_ack = 0; bus.mem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            busy_cnt = bus.mem_en ? busy_cnt + 1 : 0;
            bus.mem_ack = (bus.mem_en && ack_lat >= 0 && busy_cnt == ack_lat + 1) || (stray_ack && !bus.mem_en);
            bus.mem_rdata = bus.mem_ack ? rdata_of(bus.mem_addr) : 32'hDEADBEEF;
        end
    end

    // behavioural model: who owns the port, how long it has waited, data grants since IF last won
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_owner = 0; m_busy = 0; m_streak = 0; m_err = 0;
                chk1("rst_mem_en", bus.mem_en, 1'b0);
                chk1("rst_err", bus.err, 1'b0);
                continue;
            end
            m_ack  = m_owner != 0 && bus.mem_ack;
            m_tmo  = m_owner != 0 && !bus.mem_ack && m_busy == TMO;
            m_done = m_ack || m_tmo;
            e_ifr  = m_owner == 1 && m_done;
            e_dmr  = m_owner == 2 && m_done;
            chk1("mem_en", bus.mem_en, m_owner != 0);
            chk1("if_ready", bus.if_ready, e_ifr);
            chk1("dm_ready", bus.dm_ready, e_dmr);
            chk("if_rdata", bus.if_rdata, (e_ifr && m_ack) ? bus.mem_rdata : 32'h0);
            chk("dm_rdata", bus.dm_rdata, (e_dmr && m_ack) ? bus.mem_rdata : 32'h0);
            chk1("stall_if", bus.stall_if, bus.if_req && !e_ifr);
            chk1("stall_mem", bus.stall_mem, bus.dm_req && !e_dmr);
            chk1("err", bus.err, m_err);
            if (m_owner != 0) begin
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_wdata", bus.mem_wdata, m_wdata);
                chk1("mem_we", bus.mem_we, m_we);
                chk1("mem_byte", bus.mem_byte, m_byt);
            end
            if (bus.if_ready) seq = {seq, "I"};
            if (bus.dm_ready) seq = {seq, "D"};
            if (m_owner != 0) begin
                if (m_done) begin
                    m_owner = 0;
                    m_err = m_err || m_tmo;
                end else m_busy++;
            end else begin
                if (bus.dm_req && !(bus.if_req && m_streak == MAXB)) begin
                    m_owner = 2; m_addr = bus.dm_addr; m_we = bus.dm_we; m_byt = bus.dm_byte; m_wdata = bus.dm_wdata;
                    m_streak = bus.if_req ? ((m_streak < MAXB) ? m_streak + 1 : m_streak) : 0;
                end else if (bus.if_req) begin
                    m_owner = 1; m_addr = bus.if_addr; m_we = 0; m_byt = 0; m_wdata = 0; m_streak = 0;
                end else m_streak = 0;
                m_busy = 1;
            end
        end
    end

    task automatic drain(input string name, input int lim);
        int i = 0;
        while ((if_q.size() != 0 || dm_q.size() != 0 || bus.mem_en) && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk1({name, "_drained"}, if_q.size() == 0 && dm_q.size() == 0, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_dm_ready(input string name, input int lim, output int busy);
        int i = 0;
        busy = 0;
        do begin
            @(negedge clk);
            i++;
            if (bus.mem_en) busy++;
        end while (!bus.dm_ready && i < lim);
        chk1({name, "_dm_ready"}, bus.dm_ready, 1'b1);
    endtask

    initial begin
        int busy, held, i;
        @(negedge clk);
        chk1("reset_mem_en", bus.mem_en, 1'b0);
        chk1("reset_stall_if", bus.stall_if, 1'b0);
        chk1("reset_if_ready", bus.if_ready, 1'b0);
        chk1("reset_err", bus.err, 1'b0);
        @(posedge clk); #1 rst = 0;

        // single fetch, zero-wait memory
        ack_lat = 0;
        @(negedge clk);
        if_q.push_back(32'h400);
        @(negedge clk);
        chk1("t1_c0_stall_if", bus.stall_if, 1'b1);
        chk1("t1_c0_mem_en", bus.mem_en, 1'b0);
        @(negedge clk);
        chk1("t1_c1_mem_en", bus.mem_en, 1'b1);
        chk1("t1_c1_if_ready", bus.if_ready, 1'b1);
        chk("t1_c1_if_rdata", bus.if_rdata, 32'h2402000A);
        chk1("t1_c1_stall_if", bus.stall_if, 1'b0);
        drain("t1", 20);

        // simultaneous requests: data first, fetch in the idle cycle after
        seq = ""; ack_lat = 2;
        if_q.push_back(32'h404);
        dm_q.push_back('{we: 1'b0, byt: 1'b0, addr: 32'h1000, wdata: 32'h0});
        wait_dm_ready("t2", 20, busy);
        chk1("t2_stall_if_at_dm_ready", bus.stall_if, 1'b1);
        @(negedge clk);
        chk1("t2_idle_mem_en", bus.mem_en, 1'b0);
        @(negedge clk);
        chk1("t2_if_mem_en", bus.mem_en, 1'b1);
        chk("t2_if_mem_addr", bus.mem_addr, 32'h404);
        drain("t2", 30);
        chks("t2_order", seq, "DI");

        // burst limit: four data grants then one forced fetch
        seq = ""; ack_lat = 0;
        if_q.push_back(32'h500);
        for (int k = 0; k < 6; k++) dm_q.push_back('{we: 1'b0, byt: 1'b0, addr: 32'h3000 + 32'(4 * k), wdata: 32'h0});
        drain("t3", 100);
        chks("t3_order", seq, "DDDDIDD");

        // byte store with three wait cycles
        ack_lat = 3; held = 0; i = 0;
        dm_q.push_back('{we: 1'b1, byt: 1'b1, addr: 32'h1003, wdata: 32'hAB});
        do begin
            @(negedge clk);
            i++;
            if (bus.mem_en && bus.mem_we && bus.mem_byte && bus.mem_addr == 32'h1003 && bus.mem_wdata == 32'hAB) held++;
        end while (!bus.dm_ready && i < 20);
        chk1("t4_dm_ready", bus.dm_ready, 1'b1);
        chk("t4_hold_cycles", held, 32'd4);
        drain("t4", 20);

        // ack on the last allowed busy cycle wins over the watchdog
        ack_lat = TMO - 1;
        dm_q.push_back('{we: 1'b0, byt: 1'b0, addr: 32'h2000, wdata: 32'h0});
        wait_dm_ready("t5", 100, busy);
        chk("t5_busy_cycles", busy, 32'(TMO));
        chk("t5_dm_rdata", bus.dm_rdata, rdata_of(32'h2000));
        @(negedge clk);
        chk1("t5_err", bus.err, 1'b0);
        drain("t5", 20);

        // watchdog: no ack at all
        ack_lat = -1;
        dm_q.push_back('{we: 1'b0, byt: 1'b0, addr: 32'h2004, wdata: 32'h0});
        wait_dm_ready("t6", 100, busy);
        chk("t6_busy_cycles", busy, 32'(TMO));
        chk("t6_dm_rdata", bus.dm_rdata, 32'h0);
        chk1("t6_err_not_yet", bus.err, 1'b0);
        @(negedge clk);
        chk1("t6_err_set", bus.err, 1'b1);
        ack_lat = 0;
        for (int k = 0; k < 5; k++) begin
            if_q.push_back(32'h600 + 32'(4 * k));
            dm_q.push_back('{we: k[0], byt: 1'b0, addr: 32'h4000 + 32'(4 * k), wdata: 32'(k)});
        end
        drain("t6", 100);
        chk1("t6_err_sticky", bus.err, 1'b1);

        // stray ack while idle is ignored
        stray_ack = 1;
        repeat (4) begin
            @(negedge clk);
            chk1("t7_mem_en", bus.mem_en, 1'b0);
            chk1("t7_dm_ready", bus.dm_ready, 1'b0);
        end
        stray_ack = 0;
        @(negedge clk);

        // reset during a data access
        seq = ""; ack_lat = 10; i = 0;
        dm_q.push_back('{we: 1'b0, byt: 1'b0, addr: 32'h1000, wdata: 32'h0});
        while (!bus.mem_en && i < 10) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        chk1("t8_busy_before_rst", bus.mem_en, 1'b1);
        @(posedge clk); #2 rst = 1;
        #1;
        chk1("t8_async_mem_en", bus.mem_en, 1'b0);
        chk1("t8_no_dm_ready", bus.dm_ready, 1'b0);
        chk1("t8_err_cleared", bus.err, 1'b0);
        ack_lat = 1;
        @(posedge clk); #2 rst = 0;
        wait_dm_ready("t8", 20, busy);
        chk("t8_dm_rdata", bus.dm_rdata, rdata_of(32'h1000));
        drain("t8", 20);
        chks("t8_single_ready", seq, "D");
        chk1("t8_err", bus.err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
